// File: rtl/huffman_pkg.sv
// Shared types and codebook for the Huffman encoder.
// Optional build macro: HUFF_STATS_EN (statistics counters on the top level).
package huffman_pkg;

   typedef struct packed {
      logic [31:0] value;
      logic [5:0]  code;
      logic [3:0]  len;
   } cb_entry_t;

   localparam int unsigned CB_N = 6;
   localparam logic [5:0] ESC_PREFIX = 6'b111111;

   // Codes are right-aligned in the code field; len gives the number of valid bits.
   localparam cb_entry_t CODEBOOK [CB_N] = '{
      '{value: 32'd0, code: 6'b000000, len: 4'd1},
      '{value: 32'd1, code: 6'b001000, len: 4'd4},
      '{value: 32'd2, code: 6'b001001, len: 4'd4},
      '{value: 32'd3, code: 6'b010100, len: 4'd5},
      '{value: 32'd4, code: 6'b010101, len: 4'd5},
      '{value: 32'd5, code: 6'b101100, len: 4'd6}
   };

   typedef enum logic [1:0] {ST_RUN, ST_EMIT, ST_FLUSH, ST_DONE} state_t;

endpackage

// File: rtl/huffman_code_lut.sv
// Combinational symbol -> {code, len} lookup with escape fallback for small misses.
module huffman_code_lut
   import huffman_pkg::*;
#(
   parameter int unsigned ESC_W   = 4,
   parameter int unsigned MAX_LEN = 10,
   parameter int unsigned LEN_W   = 4
) (
   input  logic [31:0]        symbol,
   output logic [MAX_LEN-1:0] code,
   output logic [LEN_W-1:0]   len,
   output logic               hit,
   output logic               bad
);

   always_comb begin
      code = '0;
      len  = '0;
      hit  = 1'b0;
      bad  = 1'b0;
      for (int i = 0; i < CB_N; i++) begin
         if (!hit && symbol == CODEBOOK[i].value) begin
            hit  = 1'b1;
            code = MAX_LEN'(CODEBOOK[i].code);
            len  = LEN_W'(CODEBOOK[i].len);
         end
      end
      if (!hit) begin
         if ((symbol >> ESC_W) == 32'd0) begin
            code = MAX_LEN'({ESC_PREFIX, symbol[ESC_W-1:0]});
            len  = LEN_W'(6 + ESC_W);
         end else begin
            bad = 1'b1;
         end
      end
   end

endmodule

// File: rtl/huffman_encoder.sv
// Packs Huffman codes MSB-first into OUT_W-bit words with load/ready and valid/ready handshakes.
// Optional build macro: HUFF_STATS_EN adds saturating symbol/bit/escape counters.
module huffman_encoder
   import huffman_pkg::*;
#(
   parameter int unsigned OUT_W   = 32,
   parameter int unsigned ESC_W   = 4,
   parameter int unsigned MAX_LEN = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      symbol,
   input  logic             load,
   output logic             ready,
   input  logic             flush,
   output logic [OUT_W-1:0] out_word,
   output logic [5:0]       out_bits,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             done,
   output logic             err
`ifdef HUFF_STATS_EN
   ,
   output logic [31:0]      stat_syms,
   output logic [31:0]      stat_bits,
   output logic [15:0]      stat_esc
`endif
);

   localparam int unsigned ACC_W  = OUT_W + MAX_LEN;
   localparam int unsigned FILL_W = $clog2(ACC_W + 1);
   localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1);

   state_t              state_q, state_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [FILL_W-1:0]   fill_q, fill_d;
   logic [FILL_W-1:0]   sh;
   logic                run_q, err_q;
   logic [MAX_LEN-1:0]  lut_code;
   logic [LEN_W-1:0]    lut_len;
   logic                lut_hit, lut_bad;
   logic                accept, append, word_full;

   huffman_code_lut #(
      .ESC_W   (ESC_W),
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_lut (
      .symbol (symbol),
      .code   (lut_code),
      .len    (lut_len),
      .hit    (lut_hit),
      .bad    (lut_bad)
   );

   assign accept    = load && ready;
   assign append    = accept && !lut_bad;
   assign word_full = fill_q >= FILL_W'(OUT_W);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
         acc_q   <= '0;
         fill_q  <= '0;
         run_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         fill_q  <= fill_d;
         run_q   <= 1'b1;
         err_q   <= accept && lut_bad;
      end
   end

   // Bits below the fill point are always zero, so a flushed partial word is already padded.
   always_comb begin
      acc_d  = acc_q;
      fill_d = fill_q;
      sh     = FILL_W'(ACC_W) - fill_q - FILL_W'(lut_len);
      unique case (state_q)
         ST_RUN: begin
            if (append) begin
               acc_d  = acc_q | (ACC_W'(lut_code) << sh);
               fill_d = fill_q + FILL_W'(lut_len);
            end
         end
         ST_EMIT: begin
            if (out_ready) begin
               acc_d  = acc_q << OUT_W;
               fill_d = fill_q - FILL_W'(OUT_W);
            end
         end
         ST_FLUSH: begin
            if (out_ready && fill_q != '0) begin
               acc_d  = acc_q << OUT_W;
               fill_d = word_full ? fill_q - FILL_W'(OUT_W) : '0;
            end
         end
         ST_DONE: begin
            acc_d  = '0;
            fill_d = '0;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RUN: begin
            if (fill_d >= FILL_W'(OUT_W)) state_d = ST_EMIT;
            else if (flush && !accept)    state_d = ST_FLUSH;
         end
         ST_EMIT:  if (out_ready) state_d = ST_RUN;
         ST_FLUSH: begin
            if (fill_q == '0)                  state_d = ST_DONE;
            else if (out_ready && !word_full)  state_d = ST_DONE;
         end
         ST_DONE:  state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase
   end

   always_comb begin
      out_valid = (state_q == ST_EMIT) || (state_q == ST_FLUSH && fill_q != '0);
      out_word  = out_valid ? acc_q[ACC_W-1 -: OUT_W] : '0;
      out_bits  = '0;
      if (out_valid) out_bits = (state_q == ST_EMIT || word_full) ? 6'(OUT_W) : 6'(fill_q);
      ready     = run_q && (state_q == ST_RUN) && !word_full && !out_valid;
      done      = (state_q == ST_DONE);
      err       = err_q;
   end

`ifdef HUFF_STATS_EN
   logic [32:0] bits_sum;
   assign bits_sum = {1'b0, stat_bits} + 33'(lut_len);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_syms <= '0;
         stat_bits <= '0;
         stat_esc  <= '0;
      end else if (append) begin
         if (stat_syms != '1) stat_syms <= stat_syms + 32'd1;
         stat_bits <= bits_sum[32] ? '1 : bits_sum[31:0];
         if (!lut_hit && stat_esc != '1) stat_esc <= stat_esc + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_huffman_encoder.sv
// Directed self-checking bench for huffman_encoder; table of short streams plus multi-cycle cases.
module tb_huffman_encoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] symbol = '0;
   logic        load = 1'b0;
   logic        ready;
   logic        flush = 1'b0;
   logic [31:0] out_word;
   logic [5:0]  out_bits;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        done;
   logic        err;
`ifdef HUFF_STATS_EN
   logic [31:0] stat_syms, stat_bits;
   logic [15:0] stat_esc;
`endif

   huffman_encoder dut (
      .clk       (clk),
      .rst       (rst),
      .symbol    (symbol),
      .load      (load),
      .ready     (ready),
      .flush     (flush),
      .out_word  (out_word),
      .out_bits  (out_bits),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .done      (done),
      .err       (err)
`ifdef HUFF_STATS_EN
      ,
      .stat_syms (stat_syms),
      .stat_bits (stat_bits),
      .stat_esc  (stat_esc)
`endif
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] got_word [$];
   logic [5:0]  got_bits [$];
   int          done_cnt = 0;
   int          err_cnt  = 0;

   typedef struct {
      int              n;
      logic [0:3][31:0] syms;
      int              exp_words;
      logic [31:0]     exp_word;
      int              exp_bits;
      int              exp_err;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Output/pulse monitor, sampled on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (out_valid && out_ready) begin
               got_word.push_back(out_word);
               got_bits.push_back(out_bits);
            end
            if (done) done_cnt++;
            if (err)  err_cnt++;
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst   = 1'b1;
      load  = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      got_word.delete();
      got_bits.delete();
      done_cnt = 0;
      err_cnt  = 0;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (!ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: ready timeout, got 0, expected 1", name);
      end
   endtask

   task automatic send(input logic [31:0] s);
      @(negedge clk);
      wait_ready("send");
      symbol = s;
      load   = 1'b1;
      @(negedge clk);
      load   = 1'b0;
   endtask

   task automatic flush_and_wait(input string name);
      int n = 0;
      int start;
      @(negedge clk);
      wait_ready(name);
      start = done_cnt;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      while (done_cnt == start && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check({name, "_done"}, 64'(done_cnt - start), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      logic [79:0] s;
      vecs[0] = '{n: 3, syms: {32'd1, 32'd2, 32'd3, 32'd0}, exp_words: 1,
                  exp_word: 32'h89A0_0000, exp_bits: 13, exp_err: 0};
      vecs[1] = '{n: 1, syms: {32'd7, 32'd0, 32'd0, 32'd0}, exp_words: 1,
                  exp_word: 32'hFDC0_0000, exp_bits: 10, exp_err: 0};
      vecs[2] = '{n: 1, syms: {32'h100, 32'd0, 32'd0, 32'd0}, exp_words: 0,
                  exp_word: 32'h0, exp_bits: 0, exp_err: 1};
      vecs[3] = '{n: 1, syms: {32'd0, 32'd0, 32'd0, 32'd0}, exp_words: 1,
                  exp_word: 32'h0000_0000, exp_bits: 1, exp_err: 0};
      vecs[4] = '{n: 2, syms: {32'd4, 32'd5, 32'd0, 32'd0}, exp_words: 1,
                  exp_word: 32'hAD80_0000, exp_bits: 11, exp_err: 0};
      vecs[5] = '{n: 2, syms: {32'd15, 32'd0, 32'd0, 32'd0}, exp_words: 1,
                  exp_word: 32'hFFC0_0000, exp_bits: 11, exp_err: 0};
      vecs[6] = '{n: 1, syms: {32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0}, exp_words: 0,
                  exp_word: 32'h0, exp_bits: 0, exp_err: 1};

      // Reset values, and ready rising one cycle after release.
      @(negedge clk);
      check("rst_ready", 64'(ready), 64'd0);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_word", 64'(out_word), 64'd0);
      check("rst_bits", 64'(out_bits), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      rst = 1'b0;
      #1;
      check("ready_before_edge", 64'(ready), 64'd0);
      @(negedge clk);
      check("ready_after_edge", 64'(ready), 64'd1);

      // Table of short streams, each ended by a flush.
      for (int i = 0; i < 7; i++) begin
         do_reset();
         for (int j = 0; j < vecs[i].n; j++) send(vecs[i].syms[j]);
         if (vecs[i].exp_err != 0) check($sformatf("v%0d_err_ready", i), 64'(ready), 64'd1);
`ifdef HUFF_STATS_EN
         if (i == 0) begin
            check("stat_syms", 64'(stat_syms), 64'd3);
            check("stat_bits", 64'(stat_bits), 64'd13);
         end
`endif
         flush_and_wait($sformatf("v%0d", i));
         check($sformatf("v%0d_nwords", i), 64'(got_word.size()), 64'(vecs[i].exp_words));
         if (vecs[i].exp_words > 0 && got_word.size() > 0) begin
            check($sformatf("v%0d_word", i), 64'(got_word[0]), 64'(vecs[i].exp_word));
            check($sformatf("v%0d_bits", i), 64'(got_bits[0]), 64'(vecs[i].exp_bits));
         end
         check($sformatf("v%0d_errcnt", i), 64'(err_cnt), 64'(vecs[i].exp_err));
      end

      // 32 single-bit zero codes fill exactly one word; flush then adds nothing.
      do_reset();
      for (int j = 0; j < 32; j++) send(32'd0);
      flush_and_wait("zeros");
      check("zeros_nwords", 64'(got_word.size()), 64'd1);
      if (got_word.size() > 0) begin
         check("zeros_word", 64'(got_word[0]), 64'd0);
         check("zeros_bits", 64'(got_bits[0]), 64'd32);
      end

      // Eight escapes with backpressure; the fourth code straddles the first word boundary.
      do_reset();
      s = '0;
      for (int k = 6; k < 14; k++) s = {s[69:0], 6'h3F, 4'(k)};
      out_ready = 1'b0;
      for (int k = 6; k < 10; k++) send(32'(k));
      for (int c = 0; c < 5; c++) begin
         check($sformatf("stall%0d_valid", c), 64'(out_valid), 64'd1);
         check($sformatf("stall%0d_ready", c), 64'(ready), 64'd0);
         check($sformatf("stall%0d_word", c), 64'(out_word), 64'(s[79:48]));
         check($sformatf("stall%0d_bits", c), 64'(out_bits), 64'd32);
         @(negedge clk);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      for (int k = 10; k < 14; k++) send(32'(k));
      flush_and_wait("esc");
      check("esc_nwords", 64'(got_word.size()), 64'd3);
      if (got_word.size() == 3) begin
         check("esc_w0", 64'(got_word[0]), 64'(s[79:48]));
         check("esc_w1", 64'(got_word[1]), 64'(s[47:16]));
         check("esc_w2", 64'(got_word[2]), 64'({s[15:0], 16'h0000}));
         check("esc_b0", 64'(got_bits[0]), 64'd32);
         check("esc_b1", 64'(got_bits[1]), 64'd32);
         check("esc_b2", 64'(got_bits[2]), 64'd16);
      end

      // Reset while a word is pending discards it.
      do_reset();
      out_ready = 1'b0;
      for (int k = 6; k < 10; k++) send(32'(k));
      check("mid_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_ready", 64'(ready), 64'd0);
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_word", 64'(out_word), 64'd0);
      check("mid_rst_bits", 64'(out_bits), 64'd0);
      check("mid_rst_done", 64'(done), 64'd0);
      check("mid_rst_err", 64'(err), 64'd0);
      @(negedge clk);
      got_word.delete();
      got_bits.delete();
      done_cnt = 0;
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (5) @(negedge clk);
      check("mid_ready", 64'(ready), 64'd1);
      check("mid_nostale", 64'(got_word.size()), 64'd0);
      flush_and_wait("mid");
      check("mid_nwords", 64'(got_word.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
